// File: rtl/frame_pad_pkg.sv
// Shared definitions for the frame border-padding path: FSM states and
// default frame geometry.
package isp_pkg;

  localparam int WIDTH_DEF    = 320;
  localparam int HEIGHT_DEF   = 240;
  localparam int PADDED_WORDS = (WIDTH_DEF + 2) * (HEIGHT_DEF + 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TOP,
    ST_LEFT,
    ST_BODY,
    ST_RIGHT,
    ST_BOTTOM,
    ST_DONE
  } pad_state_t;

  function automatic int padded_words(input int w, input int h);
    return (w + 2) * (h + 2);
  endfunction

endpackage

// File: rtl/frame_pad_counter.sv
// Raster position over the bordered frame: col sweeps 0..WIDTH+1, then row
// advances; both wrap to zero after the last word of the frame.
module pad_counter import isp_pkg::*; #(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int HEIGHT = HEIGHT_DEF,
  parameter int CW     = $clog2(WIDTH + 2),
  parameter int RW     = $clog2(HEIGHT + 2)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] col_o,
  output logic [RW-1:0] row_o,
  output logic          col_last_o,
  output logic          row_last_o
);

  localparam logic [CW-1:0] COL_MAX = CW'(WIDTH + 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(HEIGHT + 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  assign col_last_o = (col_q == COL_MAX);
  assign row_last_o = (row_q == ROW_MAX);
  assign col_o      = col_q;
  assign row_o      = row_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
    end else if (en_i) begin
      if (col_last_o) begin
        col_d = '0;
        row_d = row_last_o ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/frame_pad.sv
// Wraps each WIDTH x HEIGHT camera frame in a one-word PAD_VALUE border and
// feeds the bus write FIFO, stalling the camera on border words or FIFO afull.
module frame_pad import isp_pkg::*; #(
  parameter int                WIDTH     = WIDTH_DEF,
  parameter int                HEIGHT    = HEIGHT_DEF,
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] PAD_VALUE = '0
) (
  input  logic              d5m_clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic              wr_afull,
  output logic [DATA_W-1:0] oData,
  output logic              oValid,
  output logic              busy,
  output logic              frame_done
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam int RW = $clog2(HEIGHT + 2);
  localparam logic [CW-1:0] COL_BODY_END = CW'(WIDTH);
  localparam logic [RW-1:0] ROW_BODY_END = RW'(HEIGHT);

  pad_state_t        state_q, state_d;
  logic [DATA_W-1:0] odata_q, word_d;
  logic              ovalid_q, done_q;
  logic              adv, emit, clr;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic              col_last, row_last;

  assign adv = !wr_afull;

  pad_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .CW     (CW),
    .RW     (RW)
  ) u_cnt (
    .clk_i      (d5m_clk),
    .rst_ni     (reset_n),
    .clr_i      (clr),
    .en_i       (emit),
    .col_o      (col),
    .row_o      (row),
    .col_last_o (col_last),
    .row_last_o (row_last)
  );

  // The counter tracks the raster position of the next word; state only
  // selects the word source and the stall rule.
  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    clr     = 1'b0;
    word_d  = PAD_VALUE;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_TOP;
          clr     = 1'b1;
        end
      end
      ST_TOP: begin
        if (adv) begin
          emit = 1'b1;
          if (col_last) state_d = ST_LEFT;
        end
      end
      ST_LEFT: begin
        if (adv) begin
          emit    = 1'b1;
          state_d = ST_BODY;
        end
      end
      ST_BODY: begin
        if (adv && pix_valid) begin
          emit   = 1'b1;
          word_d = pix_data;
          if (col == COL_BODY_END) state_d = ST_RIGHT;
        end
      end
      ST_RIGHT: begin
        if (adv) begin
          emit    = 1'b1;
          state_d = (row == ROW_BODY_END) ? ST_BOTTOM : ST_LEFT;
        end
      end
      ST_BOTTOM: begin
        if (adv) begin
          emit = 1'b1;
          if (col_last && row_last) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign pix_ready  = (state_q == ST_BODY) && adv;
  assign busy       = (state_q != ST_IDLE);
  assign oData      = odata_q;
  assign oValid     = ovalid_q;
  assign frame_done = done_q;

  always_ff @(posedge d5m_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ovalid_q <= emit;
      done_q   <= (state_q == ST_DONE);
      if (emit) odata_q <= word_d;
    end
  end

endmodule

// File: tb/tb_frame_pad.sv
// Bench for frame_pad: a 4x3 instance under varied stimulus and a full-size
// 320x240 instance, both checked against a raster-position model.
module tb_frame_pad;
  import isp_pkg::*;

  localparam int SW   = 4;
  localparam int SH   = 3;
  localparam int STOT = (SW + 2) * (SH + 2);
  localparam int BW   = WIDTH_DEF;
  localparam int BH   = HEIGHT_DEF;
  localparam int BTOT = PADDED_WORDS;
  localparam logic [31:0] SPAD = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        s_start = 0, s_pix_valid = 0, s_afull = 0;
  logic [31:0] s_pix_data = '0;
  logic        s_pix_ready, s_ovalid, s_busy, s_done;
  logic [31:0] s_odata;

  logic        b_start = 0, b_pix_valid = 0, b_afull = 0;
  logic [31:0] b_pix_data = '0;
  logic        b_pix_ready, b_ovalid, b_busy, b_done;
  logic [31:0] b_odata;

  frame_pad #(.WIDTH(SW), .HEIGHT(SH), .DATA_W(32), .PAD_VALUE(SPAD)) u_small (
    .d5m_clk(clk), .reset_n(reset_n), .start(s_start), .pix_data(s_pix_data),
    .pix_valid(s_pix_valid), .pix_ready(s_pix_ready), .wr_afull(s_afull),
    .oData(s_odata), .oValid(s_ovalid), .busy(s_busy), .frame_done(s_done));

  frame_pad #(.WIDTH(BW), .HEIGHT(BH), .DATA_W(32), .PAD_VALUE(32'h0)) u_big (
    .d5m_clk(clk), .reset_n(reset_n), .start(b_start), .pix_data(b_pix_data),
    .pix_valid(b_pix_valid), .pix_ready(b_pix_ready), .wr_afull(b_afull),
    .oData(b_odata), .oValid(b_ovalid), .busy(b_busy), .frame_done(b_done));

  int total = 0;
  int bad = 0;

  logic [31:0] pix_mem [SW*SH];
  logic [31:0] s_words [STOT];
  int s_idx = 0, s_pidx = 0, s_dones = 0;
  bit s_active = 0, s_prev_afull = 0, s_prev_vld = 0, s_acc = 0;
  int b_idx = 0, b_pidx = 0, b_dones = 0;
  bit b_active = 0, b_prev_vld = 0;
  logic [31:0] b_w323 = '0, b_w77600 = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic bit inner(input int n, input int w, input int h);
    int r, c;
    if (n >= (w + 2) * (h + 2)) return 1'b0;
    r = n / (w + 2);
    c = n % (w + 2);
    return (r >= 1 && r <= h && c >= 1 && c <= w);
  endfunction

  function automatic logic [31:0] exp_small(input int n);
    int r, c;
    r = n / (SW + 2);
    c = n % (SW + 2);
    if (!inner(n, SW, SH)) return SPAD;
    return pix_mem[(r - 1) * SW + c - 1];
  endfunction

  function automatic logic [31:0] exp_big(input int n);
    int r, c;
    r = n / (BW + 2);
    c = n % (BW + 2);
    if (!inner(n, BW, BH)) return 32'h0;
    return 32'((r - 1) * BW + c);
  endfunction

  task automatic sample();
    if (!reset_n) begin
      s_acc = 0;
      return;
    end
    s_acc = s_pix_valid && s_pix_ready;
    if (s_acc) s_pidx++;
    if (s_ovalid) begin
      if (s_active && s_idx < STOT) begin
        chk("s_word", s_odata, exp_small(s_idx));
        s_words[s_idx] = s_odata;
        s_idx++;
      end else begin
        chk("s_extra_word", 32'(s_ovalid), 32'd0);
      end
    end
    if (s_prev_afull) chk("s_stall_valid", 32'(s_ovalid), 32'd0);
    if (s_done) begin
      chk("s_done_word_count", 32'(s_idx), 32'(STOT));
      chk("s_done_after_last", 32'(s_prev_vld), 32'd1);
      s_dones++;
      s_active = 0;
    end
    chk("s_busy", 32'(s_busy), 32'(s_active));
    chk("s_pix_ready", 32'(s_pix_ready), 32'(s_active && inner(s_idx, SW, SH) && !s_afull));
    if (s_start && !s_busy) begin
      s_active = 1;
      s_idx = 0;
      s_pidx = 0;
    end
    s_prev_afull = s_afull;
    s_prev_vld = s_ovalid;

    if (b_pix_valid && b_pix_ready) b_pidx++;
    if (b_ovalid) begin
      if (b_active && b_idx < BTOT) begin
        chk("b_word", b_odata, exp_big(b_idx));
        if (b_idx == 323) b_w323 = b_odata;
        if (b_idx == 77600) b_w77600 = b_odata;
        b_idx++;
      end else begin
        chk("b_extra_word", 32'(b_ovalid), 32'd0);
      end
    end
    if (b_done) begin
      chk("b_done_word_count", 32'(b_idx), 32'(BTOT));
      chk("b_done_after_last", 32'(b_prev_vld), 32'd1);
      b_dones++;
      b_active = 0;
    end
    chk("b_busy", 32'(b_busy), 32'(b_active));
    if (b_start && !b_busy) begin
      b_active = 1;
      b_idx = 0;
      b_pidx = 0;
    end
    b_prev_vld = b_ovalid;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  // mode 0: streaming, 1: 5-cycle stall, 2: 50% valid, 3: random all,
  // 4: reset in row 2, 5: start pulses while busy and in DONE
  task automatic run_small(input int mode);
    int d0, budget, stall_left;
    bit stalled, mid_started, done_started;
    d0 = s_dones;
    stall_left = 0;
    stalled = 0;
    mid_started = 0;
    done_started = 0;
    for (int k = 0; k < SW * SH; k++) pix_mem[k] = (mode == 3) ? $urandom : 32'(k + 1);
    s_start = 1;
    tick();
    budget = 0;
    while (s_dones == d0 && budget < 3000) begin
      s_start = 0;
      if (mode == 5 && !mid_started && s_idx == 15) begin
        s_start = 1;
        mid_started = 1;
      end
      if (mode == 5 && !done_started && s_ovalid && s_idx == STOT - 1) begin
        s_start = 1;
        done_started = 1;
      end
      if (mode == 1) begin
        if (!stalled && s_idx >= 8) begin
          stalled = 1;
          stall_left = 5;
        end
        s_afull = (stall_left > 0);
        if (stall_left > 0) stall_left--;
      end else if (mode == 3) begin
        s_afull = ($urandom % 4) == 0;
      end else begin
        s_afull = 0;
      end
      if (mode == 2 || mode == 3) begin
        if (!(s_pix_valid && !s_acc)) s_pix_valid = ($urandom % 2) == 1;
      end else begin
        s_pix_valid = 1;
      end
      s_pix_data = (s_pidx < SW * SH) ? pix_mem[s_pidx] : 32'h0;
      if (mode == 4 && s_idx >= 2 * (SW + 2) + 1) begin
        reset_n = 0;
        #1;
        chk("rst_ovalid", 32'(s_ovalid), 32'd0);
        chk("rst_odata", s_odata, 32'd0);
        chk("rst_busy", 32'(s_busy), 32'd0);
        chk("rst_pix_ready", 32'(s_pix_ready), 32'd0);
        chk("rst_frame_done", 32'(s_done), 32'd0);
        s_active = 0;
        s_pix_valid = 0;
        s_afull = 0;
        tick();
        tick();
        reset_n = 1;
        repeat (6) tick();
        chk("rst_no_done", 32'(s_dones - d0), 32'd0);
        return;
      end
      tick();
      budget++;
    end
    chk("s_frame_finished", 32'(s_dones - d0), 32'd1);
    chk("s_frame_words", 32'(s_idx), 32'(STOT));
    s_start = 0;
    s_pix_valid = 0;
    s_afull = 0;
    repeat (8) tick();
    chk("s_single_done", 32'(s_dones - d0), 32'd1);
  endtask

  task automatic run_big();
    int budget;
    int d0;
    d0 = b_dones;
    b_start = 1;
    tick();
    b_start = 0;
    budget = 0;
    while (b_dones == d0 && budget < 80000) begin
      b_pix_valid = 1;
      b_pix_data = 32'(b_pidx + 1);
      tick();
      budget++;
    end
    chk("b_frame_finished", 32'(b_dones - d0), 32'd1);
    chk("b_frame_words", 32'(b_idx), 32'(BTOT));
    chk("b_word323", b_w323, 32'd1);
    chk("b_word77600", b_w77600, 32'd76800);
    b_pix_valid = 0;
    repeat (4) tick();
  endtask

  initial begin
    reset_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ovalid", 32'(s_ovalid), 32'd0);
    chk("reset_odata", s_odata, 32'd0);
    chk("reset_busy", 32'(s_busy), 32'd0);
    chk("reset_pix_ready", 32'(s_pix_ready), 32'd0);
    chk("reset_frame_done", 32'(s_done), 32'd0);
    reset_n = 1;
    repeat (2) tick();

    run_small(0);
    chk("lit_w0", s_words[0], SPAD);
    chk("lit_w6", s_words[6], SPAD);
    chk("lit_w7", s_words[7], 32'd1);
    chk("lit_w10", s_words[10], 32'd4);
    chk("lit_w11", s_words[11], SPAD);
    chk("lit_w13", s_words[13], 32'd5);
    chk("lit_w22", s_words[22], 32'd12);
    chk("lit_w29", s_words[29], SPAD);

    run_small(1);
    run_small(2);
    run_small(3);
    run_small(3);
    run_small(4);
    run_small(0);
    run_small(5);
    run_big();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
